adc_scan_scheduler: RTL and testbench
=====================================

// Module: adc_scan_scheduler
// PURPOSE
//  Sequences the 8-channel serial ADC conversion engine: scans channels selected by an enable mask at a
//  programmable rate, issues one transfer at a time over a start/done handshake, and tags each returned
//  sample with its channel. The ADC pipeline is one transfer deep: transfer k returns transfer k-1's sample.
//  Sits between the ADC SPI engine and consumers (LED/display logic, streaming); holds latest value per channel.
// PARAMETERS
//  NUM_CH    8   number of ADC channels
//  CH_W      3   channel index width, clog2(NUM_CH)
//  DATA_W    12  ADC sample width
//  PERIOD_W  16  scan-period counter width
//  AVG_LOG2  2   log2 samples averaged per channel (AVG build only)
// PORTS
//  CLOCK       in   1         system clock (50 MHz); all logic on rising edge
//  RESET       in   1         synchronous, active-high reset
//  ch_mask     in   NUM_CH    channel enable mask, sampled at scan start
//  scan_period in   PERIOD_W  cycles from one scan start to the next; 0 = back-to-back
//  xfer_start  out  1         one-cycle pulse: engine begins transfer
//  xfer_ch     out  CH_W      channel configured by this transfer; held stable while xfer_busy
//  xfer_done   in   1         one-cycle pulse: transfer complete, xfer_data valid this cycle
//  xfer_data   in   DATA_W    sample from the PREVIOUS transfer's channel
//  res_valid   out  1         one-cycle pulse: res_ch/res_data valid
//  res_ch      out  CH_W      channel of published result
//  res_data    out  DATA_W    published sample (or mean)
//  scan_done   out  1         one-cycle pulse after final result of a scan
//  xfer_busy   out  1         high from xfer_start until xfer_done
//  rd_ch       in   CH_W      read-port channel select
//  rd_data     out  DATA_W    latest published value of rd_ch, combinational read
// BEHAVIOUR
//  Reset: all outputs 0, result registers 0, period counter 0, FSM IDLE, no pending tag.
//  FSM: IDLE -> (mask!=0) LATCH -> START -> WAIT -> (more) START | FLUSH_START -> FLUSH_WAIT -> DONE -> TICK
//   LATCH: capture ch_mask into scan_mask; pointer = lowest set bit. mask==0: remain IDLE, no transfers.
//   START: xfer_start=1, xfer_ch=pointer; next cycle WAIT. WAIT: hold until xfer_done.
//   On xfer_done: if tag valid, publish xfer_data with tag channel; tag <= current channel; advance pointer
//    to next higher set bit of scan_mask; none left -> FLUSH.
//   FLUSH: one dummy transfer re-using last channel config; its data publishes the last channel.
//   First transfer of every scan has no valid tag: its data discarded (never published).
//   DONE: scan_done pulse one cycle after last res_valid; TICK waits until period counter expires, then LATCH.
//  Transfers per scan = popcount(scan_mask)+1; results per scan = popcount(scan_mask).
//  Latency: res_valid asserts the cycle after the xfer_done carrying that sample (registered output).
//  Period counter starts at LATCH; if scan longer than scan_period, next LATCH follows DONE directly.
//  ch_mask changes mid-scan ignored until next LATCH. scan_period sampled at LATCH.
//  Spurious xfer_done while not in WAIT/FLUSH_WAIT: ignored. xfer_start never reasserted while busy.
//  RESET mid-transfer: abort immediately; pending tag discarded; engine is reset by same RESET.
//  Result register of channel c updated in same cycle res_valid pulses for c; rd_data reflects it next cycle.
// CONFIGURATION
//  ADC_SCHED_AVG_EN defined: per-channel accumulator (DATA_W+AVG_LOG2 bits) and sample counter;
//   each tagged sample accumulates; on 2^AVG_LOG2-th sample publish acc>>AVG_LOG2 (truncating), clear acc.
//   res_valid/result-register updates only on publish; scan_done still pulses every scan. Reset clears accs.
//  Not defined: every tagged sample published unmodified; no accumulators synthesized.
// STRUCTURE
//  Package adc_sched_pkg: FSM state enum, NUM_CH/CH_W/DATA_W constants, next_set_bit() function.
//  Sub-module adc_avg_accum (one per channel, generate loop), instantiated only under ADC_SCHED_AVG_EN.
//  Engine BFM in bench: xfer_done 20 cycles after xfer_start, returns data of prior configured channel.
// TESTING
//  Mask 8'hFF, period 0, channel c returns 12'h100+c -> 9 transfers/scan, res_ch 0..7 with 12'h100..107, scan_done.
//  Mask 8'b1010_0100 -> xfer_ch 2,5,7,7; results ch2,5,7 only; first transfer's data never published.
//  Mask 0 after reset -> xfer_start never pulses for 1000 cycles; all outputs 0.
//  Period 1000, mask 8'h01 -> LATCH every 1000 cycles exactly; mask change to 8'h03 mid-scan applies next scan.
//  RESET asserted during WAIT -> next cycle all outputs 0, FSM IDLE; resumed scan discards first transfer again.
//  AVG build, ch0 samples 10,11,12,13 -> single res_valid with 11; rd_ch=0 gives 11.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared constants, FSM state encoding and channel-search helper for the ADC scan scheduler.
package adc_sched_pkg;

  localparam int NUM_CH   = 8;
  localparam int CH_W     = 3;
  localparam int DATA_W   = 12;
  localparam int PERIOD_W = 16;
  localparam int AVG_LOG2 = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LATCH       = 3'd1,
    ST_START       = 3'd2,
    ST_WAIT        = 3'd3,
    ST_FLUSH_START = 3'd4,
    ST_FLUSH_WAIT  = 3'd5,
    ST_DONE        = 3'd6,
    ST_TICK        = 3'd7
  } state_e;

  // Lowest set bit of mask at index >= from; MSB of the result flags "found".
  function automatic logic [CH_W:0] next_set_bit(input logic [NUM_CH-1:0] mask,
                                                 input logic [CH_W:0]     from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        res = {1'b1, CH_W'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Per-channel sample averager: publishes the truncated mean of every 2^AVG_LOG2 samples.
// Only compiled into the design when ADC_SCHED_AVG_EN is defined.
`ifdef ADC_SCHED_AVG_EN
module adc_avg_accum
  import adc_sched_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              pub_valid_o,
  output logic [DATA_W-1:0] pub_data_o
);

  logic [DATA_W+AVG_LOG2-1:0] acc_q, acc_d, sum_s;
  logic [AVG_LOG2-1:0]        cnt_q, cnt_d;

  // Sum includes the current sample so the publish cycle needs no extra register stage.
  always_comb begin
    sum_s       = acc_q + {{AVG_LOG2{1'b0}}, sample_i};
    pub_valid_o = sample_valid_i && (cnt_q == '1);
    pub_data_o  = sum_s[DATA_W+AVG_LOG2-1:AVG_LOG2];
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (sample_valid_i) begin
      cnt_d = cnt_q + AVG_LOG2'(1);
      acc_d = pub_valid_o ? '0 : sum_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/adc_scan_scheduler.sv
// Scans enabled ADC channels over a one-deep start/done pipeline and tags returned samples.
// Optional ADC_SCHED_AVG_EN adds per-channel averaging before publication.
module adc_scan_scheduler
  import adc_sched_pkg::*;
(
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [PERIOD_W-1:0] scan_period,
  output logic                xfer_start,
  output logic [CH_W-1:0]     xfer_ch,
  input  logic                xfer_done,
  input  logic [DATA_W-1:0]   xfer_data,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [DATA_W-1:0]   res_data,
  output logic                scan_done,
  output logic                xfer_busy,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [DATA_W-1:0]   rd_data
);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   scan_mask_q, scan_mask_d;
  logic [CH_W-1:0]     xfer_ch_q, xfer_ch_d;
  logic [CH_W-1:0]     tag_q, tag_d;
  logic                tag_valid_q, tag_valid_d;
  logic [PERIOD_W-1:0] rem_q, rem_d;
  logic                xfer_start_q, xfer_start_d;
  logic                busy_q, busy_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                scan_done_q, scan_done_d;
  logic [DATA_W-1:0]   result_q [NUM_CH];
  logic [CH_W:0]       nxt_s;
  logic                sample_ev_s;
  logic                pub_valid_s;
  logic [DATA_W-1:0]   pub_data_s;

  // rem_q counts down the cycles left until the next scan may latch.
  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    xfer_ch_d   = xfer_ch_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    rem_d       = (rem_q != '0) ? rem_q - PERIOD_W'(1) : '0;
    scan_done_d = 1'b0;
    sample_ev_s = 1'b0;
    nxt_s       = '0;
    case (state_q)
      ST_IDLE: begin
        if (ch_mask != '0) state_d = ST_LATCH;
        else               state_d = ST_IDLE;
      end
      ST_LATCH: begin
        scan_mask_d = ch_mask;
        tag_valid_d = 1'b0;
        rem_d       = (scan_period == '0) ? '0 : scan_period - PERIOD_W'(1);
        nxt_s       = next_set_bit(ch_mask, (CH_W+1)'(0));
        if (nxt_s[CH_W]) begin
          xfer_ch_d = nxt_s[CH_W-1:0];
          state_d   = ST_START;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_START:       state_d = ST_WAIT;
      ST_WAIT: begin
        if (xfer_done) begin
          sample_ev_s = tag_valid_q;
          tag_d       = xfer_ch_q;
          tag_valid_d = 1'b1;
          nxt_s       = next_set_bit(scan_mask_q, {1'b0, xfer_ch_q} + (CH_W+1)'(1));
          if (nxt_s[CH_W]) begin
            xfer_ch_d = nxt_s[CH_W-1:0];
            state_d   = ST_START;
          end else begin
            state_d   = ST_FLUSH_START;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FLUSH_START: state_d = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: begin
        if (xfer_done) begin
          sample_ev_s = tag_valid_q;
          tag_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_FLUSH_WAIT;
        end
      end
      ST_DONE: begin
        scan_done_d = 1'b1;
        if (rem_q <= PERIOD_W'(1)) state_d = ST_LATCH;
        else                       state_d = ST_TICK;
      end
      ST_TICK: begin
        if (rem_q <= PERIOD_W'(1)) state_d = ST_LATCH;
        else                       state_d = ST_TICK;
      end
      default: state_d = ST_IDLE;
    endcase
    xfer_start_d = (state_d == ST_START) || (state_d == ST_FLUSH_START);
    busy_d       = (state_d == ST_START) || (state_d == ST_WAIT) ||
                   (state_d == ST_FLUSH_START) || (state_d == ST_FLUSH_WAIT);
  end

`ifdef ADC_SCHED_AVG_EN
  logic [NUM_CH-1:0] acc_pub_s;
  logic [DATA_W-1:0] acc_data_s [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_acc
    adc_avg_accum u_acc (
      .clk_i          (CLOCK),
      .rst_i          (RESET),
      .sample_valid_i (sample_ev_s && (tag_q == CH_W'(g))),
      .sample_i       (xfer_data),
      .pub_valid_o    (acc_pub_s[g]),
      .pub_data_o     (acc_data_s[g])
    );
  end

  assign pub_valid_s = |acc_pub_s;
  assign pub_data_s  = acc_data_s[tag_q];
`else
  assign pub_valid_s = sample_ev_s;
  assign pub_data_s  = xfer_data;
`endif

  // Result bus; kept apart from the FSM block so the publish path has no feedback into it.
  always_comb begin
    res_valid_d = pub_valid_s;
    if (pub_valid_s) begin
      res_ch_d   = tag_q;
      res_data_d = pub_data_s;
    end else begin
      res_ch_d   = res_ch_q;
      res_data_d = res_data_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      scan_mask_q  <= '0;
      xfer_ch_q    <= '0;
      tag_q        <= '0;
      tag_valid_q  <= 1'b0;
      rem_q        <= '0;
      xfer_start_q <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_data_q   <= '0;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_mask_q  <= scan_mask_d;
      xfer_ch_q    <= xfer_ch_d;
      tag_q        <= tag_d;
      tag_valid_q  <= tag_valid_d;
      rem_q        <= rem_d;
      xfer_start_q <= xfer_start_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_ch_q     <= res_ch_d;
      res_data_q   <= res_data_d;
      scan_done_q  <= scan_done_d;
    end
  end

  // Latest published value per channel, written on the same edge that raises res_valid.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else if (pub_valid_s) begin
      result_q[tag_q] <= pub_data_s;
    end
  end

  assign xfer_start = xfer_start_q;
  assign xfer_ch    = xfer_ch_q;
  assign xfer_busy  = busy_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_data   = res_data_q;
  assign scan_done  = scan_done_q;
  assign rd_data    = result_q[rd_ch];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with an ADC engine model and result scoreboard.
// Build with ADC_SCHED_AVG_EN to exercise the averaging variant instead of the plain scan tests.
module tb_adc_scan_scheduler;
  import adc_sched_pkg::*;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  ch_mask = 8'h00;
  logic [15:0] scan_period = 16'd0;
  logic        xfer_start, xfer_done, res_valid, scan_done, xfer_busy;
  logic [2:0]  xfer_ch, res_ch;
  logic [2:0]  rd_ch = 3'd0;
  logic [11:0] xfer_data, res_data, rd_data;
  logic        bfm_done = 1'b0;
  logic        spur_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int sd_cnt = 0;
  int cyc    = 0;
  int base;
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];
  logic [2:0]  xs_ch_q[$];
  int          xs_cyc_q[$];
  logic [11:0] ch_val [8];

  logic        eng_busy = 1'b0, prev_valid = 1'b0;
  logic [2:0]  cur_ch = 3'd0, prev_ch = 3'd0;
  int          eng_cnt = 0;

  assign xfer_done = bfm_done | spur_done;

  adc_scan_scheduler dut (
    .CLOCK(CLOCK), .RESET(RESET), .ch_mask(ch_mask), .scan_period(scan_period),
    .xfer_start(xfer_start), .xfer_ch(xfer_ch), .xfer_done(xfer_done), .xfer_data(xfer_data),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data), .scan_done(scan_done),
    .xfer_busy(xfer_busy), .rd_ch(rd_ch), .rd_data(rd_data)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Engine model: done 20 cycles after start, data belongs to the previously configured channel.
  always @(posedge CLOCK) begin
    bfm_done <= 1'b0;
    if (RESET) begin
      eng_busy   <= 1'b0;
      prev_valid <= 1'b0;
      eng_cnt    <= 0;
      xfer_data  <= 12'h000;
    end else if (xfer_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 1;
      cur_ch   <= xfer_ch;
    end else if (eng_busy) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 19) begin
        bfm_done   <= 1'b1;
        xfer_data  <= prev_valid ? ch_val[prev_ch] : 12'hBAD;
        prev_ch    <= cur_ch;
        prev_valid <= 1'b1;
        eng_busy   <= 1'b0;
      end
    end
  end

  always @(negedge CLOCK) begin
    if (!RESET) begin
      if (res_valid) obs_q.push_back({res_ch, res_data});
      if (xfer_start) begin
        xs_ch_q.push_back(xfer_ch);
        xs_cyc_q.push_back(cyc);
      end
      if (scan_done) sd_cnt <= sd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic wait_sd(input int target, input int budget);
    int t = 0;
    while (sd_cnt < target && t < budget) begin
      @(negedge CLOCK);
      t++;
    end
    chk("scan_done_timeout", 32'(sd_cnt >= target), 32'd1);
  endtask

  task automatic wait_xs(input int target, input int budget);
    int t = 0;
    while (xs_ch_q.size() < target && t < budget) begin
      @(negedge CLOCK);
      t++;
    end
    chk("xfer_start_timeout", 32'(xs_ch_q.size() >= target), 32'd1);
  endtask

  task automatic clear_mon();
    exp_q.delete();
    obs_q.delete();
    xs_ch_q.delete();
    xs_cyc_q.delete();
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_xfer_start"}, xfer_start, 0);
    chk({tag, "_xfer_busy"}, xfer_busy, 0);
    chk({tag, "_xfer_ch"}, xfer_ch, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_ch"}, res_ch, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    for (int c = 0; c < 8; c++) ch_val[c] = 12'h100 + 12'(c);
    wait_cycles(3);
    check_outputs_zero("reset");
    RESET = 1'b0;

    // Empty mask stays idle; a stray done must not publish anything.
    wait_cycles(500);
    spur_done = 1'b1;
    wait_cycles(1);
    spur_done = 1'b0;
    wait_cycles(500);
    chk("idle_xfer_count", xs_ch_q.size(), 0);
    chk("idle_res_count", obs_q.size(), 0);
    chk("idle_scan_done", sd_cnt, 0);
    chk("idle_busy", xfer_busy, 0);

`ifdef ADC_SCHED_AVG_EN
    clear_mon();
    ch_val[0] = 12'd10;
    exp_q.push_back({3'd0, 12'd11});
    base = sd_cnt;
    ch_mask = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      wait_sd(base + k, 200);
      ch_val[0] = 12'(10 + k);
      if (k == 3) ch_mask = 8'h00;
    end
    wait_sd(base + 4, 200);
    wait_cycles(50);
    chk("avg_xfer_count", xs_ch_q.size(), 8);
    check_sb("avg_result");
    rd_ch = 3'd0;
    wait_cycles(1);
    chk("avg_rd_data", rd_data, 12'd11);
`else
    // Full mask, back-to-back.
    clear_mon();
    for (int c = 0; c < 8; c++) exp_q.push_back({3'(c), 12'h100 + 12'(c)});
    base = sd_cnt;
    ch_mask = 8'hFF;
    wait_xs(1, 50);
    chk("ff_busy", xfer_busy, 1);
    ch_mask = 8'h00;
    wait_sd(base + 1, 500);
    wait_cycles(50);
    chk("ff_xfer_count", xs_ch_q.size(), 9);
    for (int i = 0; i < 9 && i < xs_ch_q.size(); i++) chk("ff_xfer_ch", xs_ch_q[i], (i < 8) ? i : 7);
    check_sb("ff_result");
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c);
      wait_cycles(1);
      chk("ff_rd_data", rd_data, 12'h100 + 12'(c));
    end

    // Sparse mask 1010_0100.
    clear_mon();
    exp_q.push_back({3'd2, 12'h102});
    exp_q.push_back({3'd5, 12'h105});
    exp_q.push_back({3'd7, 12'h107});
    base = sd_cnt;
    ch_mask = 8'hA4;
    wait_xs(1, 50);
    ch_mask = 8'h00;
    wait_sd(base + 1, 500);
    wait_cycles(50);
    chk("a4_xfer_count", xs_ch_q.size(), 4);
    if (xs_ch_q.size() >= 4) begin
      chk("a4_xfer_ch0", xs_ch_q[0], 2);
      chk("a4_xfer_ch1", xs_ch_q[1], 5);
      chk("a4_xfer_ch2", xs_ch_q[2], 7);
      chk("a4_xfer_ch3", xs_ch_q[3], 7);
    end
    check_sb("a4_result");

    // Period 1000; mask widened to 03 mid-scan takes effect on the following scan.
    clear_mon();
    exp_q.push_back({3'd0, 12'h100});
    exp_q.push_back({3'd0, 12'h100});
    exp_q.push_back({3'd0, 12'h100});
    exp_q.push_back({3'd1, 12'h101});
    base = sd_cnt;
    scan_period = 16'd1000;
    ch_mask = 8'h01;
    wait_xs(3, 1200);
    ch_mask = 8'h03;
    wait_xs(5, 1200);
    ch_mask = 8'h00;
    wait_sd(base + 3, 1200);
    wait_cycles(1200);
    chk("per_xfer_count", xs_ch_q.size(), 7);
    if (xs_ch_q.size() >= 7) begin
      chk("per_gap_1", xs_cyc_q[2] - xs_cyc_q[0], 1000);
      chk("per_gap_2", xs_cyc_q[4] - xs_cyc_q[2], 1000);
      chk("per_s3_ch0", xs_ch_q[4], 0);
      chk("per_s3_ch1", xs_ch_q[5], 1);
      chk("per_s3_ch2", xs_ch_q[6], 1);
    end
    check_sb("per_result");
    scan_period = 16'd0;

    // Reset while waiting on a transfer, then a clean rescan.
    clear_mon();
    rd_ch = 3'd0;
    ch_mask = 8'hFF;
    wait_xs(1, 50);
    wait_cycles(5);
    chk("rstw_busy", xfer_busy, 1);
    RESET = 1'b1;
    wait_cycles(1);
    check_outputs_zero("rstw");
    clear_mon();
    for (int c = 0; c < 8; c++) exp_q.push_back({3'(c), 12'h100 + 12'(c)});
    base = sd_cnt;
    RESET = 1'b0;
    wait_xs(1, 50);
    ch_mask = 8'h00;
    wait_sd(base + 1, 500);
    wait_cycles(50);
    chk("rstw_xfer_count", xs_ch_q.size(), 9);
    check_sb("rstw_result");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
